// File: rtl/pwm_capture_if.sv
// pwm_capture_if: valid/ready measurement stream carrying one PWM cycle's
// high time and period.
//   m_valid   : a measurement is held on high_time/period
//   m_ready   : downstream accepts the measurement
//   high_time : cycles the conditioned input was 1 within the period
//   period    : cycles between consecutive rising edges
// master = producer (pwm_capture), slave = consumer.
interface pwm_capture_if #(parameter int width = 16);
  logic             m_valid;
  logic             m_ready;
  logic [width-1:0] high_time;
  logic [width-1:0] period;

  modport master (output m_valid, high_time, period, input m_ready);
  modport slave  (input m_valid, high_time, period, output m_ready);
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of a PWM input, in clk cycles,
// for every complete input cycle and presents each result on a valid/ready
// stream. A missing rising edge for 2^width-1 cycles raises timeout and drops
// back to IDLE; a result completed while the previous one is still unaccepted
// is dropped and flagged with overrun.
// Optional build macro: PWM_CAPTURE_SYNC_EN adds a two-flop synchronizer on
// din (one extra cycle of latency, counts unchanged).
// Ports:
//   clk      : clock
//   rst_n    : synchronous reset, active low
//   din      : PWM input
//   m        : measurement stream (pwm_capture_if master)
//   timeout  : one-cycle pulse, no rising edge within 2^width-1 cycles
//   overrun  : one-cycle pulse, a completed measurement was dropped
module pwm_capture #(
  parameter int width = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           din,
  pwm_capture_if.master  m,
  output logic           timeout,
  output logic           overrun
);
  localparam logic [width-1:0] CNT_MAX = '1;
  localparam logic [width-1:0] CNT_ONE = width'(1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state, state_nxt;
  logic             din_s, din_d, rise;
  logic [width-1:0] period_cnt, period_nxt;
  logic [width-1:0] high_cnt, high_nxt;
  logic             publish, timeout_nxt;

  // Input conditioning: din_s is the value the counters see.
`ifdef PWM_CAPTURE_SYNC_EN
  logic din_meta;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_meta <= 1'b0;
      din_s    <= 1'b0;
    end else begin
      din_meta <= din;
      din_s    <= din_meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) din_s <= 1'b0;
    else        din_s <= din;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) din_d <= 1'b0;
    else        din_d <= din_s;
  end

  assign rise = din_s & ~din_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      period_cnt <= period_nxt;
      high_cnt   <= high_nxt;
    end
  end

  // The rise cycle itself is counted as the first cycle of the new period
  // (and as high), hence the reload to 1 rather than 0.
  always_comb begin
    state_nxt   = state;
    period_nxt  = period_cnt;
    high_nxt    = high_cnt;
    publish     = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        period_nxt = '0;
        high_nxt   = '0;
        if (rise) begin
          // First partial cycle is unknown-length: start counting, publish nothing.
          state_nxt  = MEASURE;
          period_nxt = CNT_ONE;
          high_nxt   = CNT_ONE;
        end
      end
      MEASURE: begin
        if (rise) begin
          publish    = 1'b1;
          period_nxt = CNT_ONE;
          high_nxt   = CNT_ONE;
        end else if (period_cnt == CNT_MAX) begin
          // Stop before the counter could wrap.
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
          period_nxt  = '0;
          high_nxt    = '0;
        end else begin
          period_nxt = period_cnt + CNT_ONE;
          if (din_s) high_nxt = high_cnt + CNT_ONE;
        end
      end
    endcase
  end

  // Output register: held data stays stable until accepted; a publish that
  // coincides with a transfer replaces it without a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m.m_valid   <= 1'b0;
      m.high_time <= '0;
      m.period    <= '0;
      timeout     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      timeout <= timeout_nxt;
      overrun <= publish & m.m_valid & ~m.m_ready;
      if (publish && (!m.m_valid || m.m_ready)) begin
        m.m_valid   <= 1'b1;
        m.high_time <= high_cnt;
        m.period    <= period_cnt;
      end else if (m.m_valid && m.m_ready) begin
        m.m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed bench for pwm_capture (width 16). Inputs change
// #1 after the rising edge; outputs are sampled at the same point. Transfers
// are logged just before each edge into a queue and compared against
// hand-computed (high_time, period) pairs.
module tb_pwm_capture;
`ifdef PWM_CAPTURE_SYNC_EN
  localparam int SD = 1;
`else
  localparam int SD = 0;
`endif

  typedef struct packed {
    logic [15:0] ht;
    logic [15:0] per;
  } meas_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  din = 1'b0;
  logic  timeout, overrun;
  meas_t q[$];
  int    checks = 0, failures = 0;
  int    cyc = 0, n_to = 0, n_ov = 0, n_vld = 0, to_cyc = 0, base = 0;

  pwm_capture_if #(.width(16)) bus ();

  pwm_capture #(.width(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .m       (bus),
    .timeout (timeout),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    if (bus.m_valid && bus.m_ready) q.push_back(meas_t'{bus.high_time, bus.period});
    @(posedge clk);
    #1;
    cyc++;
    if (timeout) begin n_to++; to_cyc = cyc; end
    if (overrun) n_ov++;
    if (bus.m_valid) n_vld++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; din = 1'b0; bus.m_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    q.delete();
    n_to = 0; n_ov = 0; n_vld = 0;
  endtask

  task automatic run_pwm(input int hi, input int per, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < per; i++) begin
        din = (i < hi);
        step();
      end
    din = 1'b0;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic check_q(input string tag, input int n, input int ht, input int per);
    chk({tag, "_count"}, q.size(), n);
    foreach (q[i]) begin
      chk({tag, "_high"}, q[i].ht, ht);
      chk({tag, "_period"}, q[i].per, per);
    end
    q.delete();
  endtask

  initial begin
    // Reset values
    bus.m_ready = 1'b0;
    step(); step();
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_high", bus.high_time, 0);
    chk("rst_period", bus.period, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_overrun", overrun, 0);

    // Duty 64 of 256: first cycle discarded, three full cycles reported
    do_reset(); bus.m_ready = 1'b1;
    run_pwm(64, 256, 4);
    check_q("d64", 3, 64, 256);
    chk("d64_overrun", n_ov, 0);
    chk("d64_timeout", n_to, 0);

    // Duty 255 of 256: one-cycle low
    do_reset(); bus.m_ready = 1'b1;
    run_pwm(255, 256, 3);
    check_q("d255", 2, 255, 256);

    // One-cycle high, 2-cycle period at full rate
    do_reset(); bus.m_ready = 1'b1;
    run_pwm(1, 2, 6);
    check_q("p2", 5, 1, 2);
    chk("p2_overrun", n_ov, 0);

    // Constant low: never leaves IDLE
    do_reset(); bus.m_ready = 1'b1;
    for (int i = 0; i < 300; i++) step();
    chk("low_valid", n_vld, 0);
    chk("low_timeout", n_to, 0);

    // 3 high / 2 low with ready held low until the 4th rise is published
    do_reset();
    for (int t = 0; t <= 17 + SD; t++) begin
      din = ((t % 5) < 3);
      bus.m_ready = (t >= 16 + SD);
      step();
      if (t == 6 + SD) begin
        chk("ov_first_valid", bus.m_valid, 1);
        chk("ov_first_high", bus.high_time, 3);
        chk("ov_first_period", bus.period, 5);
      end
      if (t == 15 + SD) begin
        chk("ov_hold_valid", bus.m_valid, 1);
        chk("ov_hold_high", bus.high_time, 3);
        chk("ov_hold_period", bus.period, 5);
        chk("ov_pulses", n_ov, 1);
        chk("ov_no_xfer", q.size(), 0);
      end
      if (t == 16 + SD) begin
        chk("ov_swap_valid", bus.m_valid, 1);
        chk("ov_swap_high", bus.high_time, 3);
        chk("ov_swap_period", bus.period, 5);
      end
      if (t == 17 + SD) chk("ov_drain_valid", bus.m_valid, 0);
    end
    check_q("ov", 2, 3, 5);

    // Latency, then a one-cycle reset mid-period while m_valid=1
    do_reset();
    for (int t = 0; t <= 15 + SD; t++) begin
      din = ((t % 4) < 2);
      bus.m_ready = (t > 7);
      rst_n = (t != 7);
      step();
      if (t == 4 + SD) chk("lat_before", bus.m_valid, 0);
      if (t == 5 + SD) chk("lat_valid", bus.m_valid, 1);
      if (t == 6) begin
        chk("mid_valid", bus.m_valid, 1);
        chk("mid_high", bus.high_time, 2);
        chk("mid_period", bus.period, 4);
      end
      if (t == 7) begin
        chk("mrst_valid", bus.m_valid, 0);
        chk("mrst_high", bus.high_time, 0);
        chk("mrst_period", bus.period, 0);
        chk("mrst_timeout", timeout, 0);
        chk("mrst_overrun", overrun, 0);
      end
    end
    check_q("mrst", 1, 2, 4);

    // Held high after one edge: single timeout, no measurement
    do_reset(); bus.m_ready = 1'b1;
    base = cyc;
    din = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    chk("to_count", n_to, 1);
    chk("to_cycle", to_cyc - base, 65537 + SD);
    chk("to_no_valid", n_vld, 0);
    din = 1'b0; step(); step();
    run_pwm(1, 3, 3);
    check_q("to_restart", 2, 1, 3);
    chk("to_no_more", n_to, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
